rsa_stream_ctrl: RTL and testbench

- Upstream sequencer for the 8-bit modular-exponentiation core (mod(A^B,C)).
- Accepts a valid/ready stream of plaintext bytes plus a loaded key (exponent, modulus).
- For each byte, drives the core's level-sensitive start/busy protocol, captures the core result, and emits it on a valid/ready output stream with an error flag.
- Converts the core's one-shot, start-as-reset interface into a back-to-back streaming interface.

---
 rtl/rsa_pkg.sv | 18 +
 rtl/rsa_stream_ctrl.sv | 198 +++++++++++++++++++
 tb/tb_rsa_stream_ctrl.sv | 413 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/rsa_pkg.sv
// Shared definitions for the RSA stream controller: data width, timing defaults and the
// controller state encoding.
package rsa_pkg;

   localparam int unsigned RSA_WIDTH            = 8;
   localparam int unsigned RSA_START_LOW_CYCLES = 2;
   localparam int unsigned RSA_TIMEOUT_CYCLES   = 4096;

   typedef enum logic [2:0] {
      StIdle    = 3'd0,
      StLaunch  = 3'd1,
      StRun     = 3'd2,
      StErr     = 3'd3,
      StOut     = 3'd4,
      StRelease = 3'd5
   } ctrl_state_e;

endpackage

// File: rtl/rsa_stream_ctrl.sv
// Streams plaintext bytes through a one-shot modexp core (start-as-reset protocol), one byte in
// flight. Optional watchdog on a stuck core is enabled by defining RSA_TIMEOUT_EN.
module rsa_stream_ctrl
   import rsa_pkg::*;
#(
   parameter int unsigned WIDTH            = RSA_WIDTH,
   parameter int unsigned START_LOW_CYCLES = RSA_START_LOW_CYCLES
`ifdef RSA_TIMEOUT_EN
   ,
   parameter int unsigned TIMEOUT_CYCLES   = RSA_TIMEOUT_CYCLES
`endif
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             key_load,
   input  logic [WIDTH-1:0] key_e,
   input  logic [WIDTH-1:0] key_n,
   output logic             key_ready,
   input  logic             in_valid,
   input  logic [WIDTH-1:0] in_data,
   input  logic             in_last,
   output logic             in_ready,
   output logic             out_valid,
   output logic [WIDTH-1:0] out_data,
   output logic             out_last,
   output logic             out_err,
   input  logic             out_ready,
   output logic             core_start,
   output logic [WIDTH-1:0] core_a,
   output logic [WIDTH-1:0] core_b,
   output logic [WIDTH-1:0] core_c,
   input  logic             core_busy,
   input  logic [WIDTH-1:0] core_y
);

   localparam int unsigned LowW = (START_LOW_CYCLES > 1) ? $clog2(START_LOW_CYCLES) : 1;

   ctrl_state_e      state_q;
   logic [WIDTH-1:0] key_e_q;
   logic [WIDTH-1:0] key_n_q;
   logic             key_valid_q;
   logic             key_bad_q;
   logic             last_q;
   logic [LowW-1:0]  low_cnt_q;
   logic             core_start_q;
   logic [WIDTH-1:0] core_a_q;
   logic [WIDTH-1:0] core_b_q;
   logic [WIDTH-1:0] core_c_q;
   logic             out_valid_q;
   logic [WIDTH-1:0] out_data_q;
   logic             out_last_q;
   logic             out_err_q;
   logic             accept;
   logic             reject;

`ifdef RSA_TIMEOUT_EN
   localparam int unsigned WdogW = $clog2(TIMEOUT_CYCLES + 1);

   logic [WdogW-1:0] wdog_q;
   logic             wdog_expired;

   assign wdog_expired = (wdog_q == WdogW'(TIMEOUT_CYCLES - 1));
`endif

   assign key_ready  = (state_q == StIdle);
   assign in_ready   = (state_q == StIdle) && key_valid_q;
   assign accept     = in_valid && in_ready;
   // Bytes the core cannot reduce, or a degenerate modulus, never reach the core.
   assign reject     = key_bad_q || (in_data >= key_n_q);

   assign core_start = core_start_q;
   assign core_a     = core_a_q;
   assign core_b     = core_b_q;
   assign core_c     = core_c_q;
   assign out_valid  = out_valid_q;
   assign out_data   = out_data_q;
   assign out_last   = out_last_q;
   assign out_err    = out_err_q;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q      <= StIdle;
         key_e_q      <= '0;
         key_n_q      <= '0;
         key_valid_q  <= 1'b0;
         key_bad_q    <= 1'b0;
         last_q       <= 1'b0;
         low_cnt_q    <= '0;
         core_start_q <= 1'b0;
         core_a_q     <= '0;
         core_b_q     <= '0;
         core_c_q     <= '0;
         out_valid_q  <= 1'b0;
         out_data_q   <= '0;
         out_last_q   <= 1'b0;
         out_err_q    <= 1'b0;
`ifdef RSA_TIMEOUT_EN
         wdog_q       <= '0;
`endif
      end else begin
         case (state_q)
            StIdle: begin
               if (key_load) begin
                  key_e_q     <= key_e;
                  key_n_q     <= key_n;
                  key_valid_q <= 1'b1;
                  key_bad_q   <= (key_n < WIDTH'(2));
               end
               if (accept) begin
                  core_a_q <= in_data;
                  core_b_q <= key_e_q;
                  core_c_q <= key_n_q;
                  last_q   <= in_last;
                  if (reject) begin
                     state_q <= StErr;
                  end else begin
                     state_q      <= StLaunch;
                     core_start_q <= 1'b1;
`ifdef RSA_TIMEOUT_EN
                     wdog_q       <= '0;
`endif
                  end
               end
            end

            // Busy is still low for the first cycle after start; that is not a completion.
            StLaunch: begin
`ifdef RSA_TIMEOUT_EN
               wdog_q <= wdog_q + WdogW'(1);
               if (wdog_expired) begin
                  core_start_q <= 1'b0;
                  state_q      <= StErr;
               end else if (core_busy) begin
                  state_q <= StRun;
               end
`else
               if (core_busy) begin
                  state_q <= StRun;
               end
`endif
            end

            StRun: begin
               if (!core_busy) begin
                  out_data_q  <= core_y;
                  out_err_q   <= 1'b0;
                  out_valid_q <= 1'b1;
                  out_last_q  <= last_q;
                  state_q     <= StOut;
               end
`ifdef RSA_TIMEOUT_EN
               else if (wdog_expired) begin
                  core_start_q <= 1'b0;
                  state_q      <= StErr;
               end else begin
                  wdog_q <= wdog_q + WdogW'(1);
               end
`endif
            end

            StErr: begin
               core_start_q <= 1'b0;
               out_data_q   <= '0;
               out_err_q    <= 1'b1;
               out_valid_q  <= 1'b1;
               out_last_q   <= last_q;
               state_q      <= StOut;
            end

            // The core keeps its result only while start stays high, so hold start until accept.
            StOut: begin
               if (out_ready) begin
                  out_valid_q  <= 1'b0;
                  core_start_q <= 1'b0;
                  low_cnt_q    <= LowW'(START_LOW_CYCLES - 1);
                  state_q      <= StRelease;
               end
            end

            StRelease: begin
               core_start_q <= 1'b0;
               if (low_cnt_q == '0) begin
                  state_q <= StIdle;
               end else begin
                  low_cnt_q <= low_cnt_q - LowW'(1);
               end
            end

            default: begin
               core_start_q <= 1'b0;
               out_valid_q  <= 1'b0;
               state_q      <= StIdle;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_rsa_stream_ctrl.sv
// Randomised self-checking bench for rsa_stream_ctrl with a behavioural modexp core model.
// Define RSA_TIMEOUT_EN to also exercise the watchdog with a stuck core.
module tb_rsa_stream_ctrl;
   import rsa_pkg::*;

   localparam int unsigned W             = RSA_WIDTH;
   localparam int          BudgetPerByte = 400;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         key_load = 1'b0;
   logic [W-1:0] key_e = '0;
   logic [W-1:0] key_n = '0;
   logic         key_ready;
   logic         in_valid = 1'b0;
   logic [W-1:0] in_data = '0;
   logic         in_last = 1'b0;
   logic         in_ready;
   logic         out_valid;
   logic [W-1:0] out_data;
   logic         out_last;
   logic         out_err;
   logic         out_ready = 1'b0;
   logic         core_start;
   logic [W-1:0] core_a;
   logic [W-1:0] core_b;
   logic [W-1:0] core_c;
   logic         core_busy = 1'b0;
   logic [W-1:0] core_y = '0;

   int num_checks = 0;
   int num_errors = 0;
   int cur_e = 0;
   int cur_n = 0;
   int lat_min = 1;
   int lat_max = 4;
   bit core_stuck = 1'b0;
   int start_cnt = 0;

   logic [W-1:0] stim_data[$];
   bit           stim_last[$];
   logic [W-1:0] exp_data[$];
   bit           exp_err[$];
   bit           exp_last[$];

   always #5 clk = ~clk;

   rsa_stream_ctrl #(
      .WIDTH           (W),
      .START_LOW_CYCLES(2)
`ifdef RSA_TIMEOUT_EN
      ,
      .TIMEOUT_CYCLES  (16)
`endif
   ) u_dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .key_load  (key_load),
      .key_e     (key_e),
      .key_n     (key_n),
      .key_ready (key_ready),
      .in_valid  (in_valid),
      .in_data   (in_data),
      .in_last   (in_last),
      .in_ready  (in_ready),
      .out_valid (out_valid),
      .out_data  (out_data),
      .out_last  (out_last),
      .out_err   (out_err),
      .out_ready (out_ready),
      .core_start(core_start),
      .core_a    (core_a),
      .core_b    (core_b),
      .core_c    (core_c),
      .core_busy (core_busy),
      .core_y    (core_y)
   );

   function automatic logic [W-1:0] ref_modexp(input int a, input int e, input int n);
      int r;
      if (n < 2) return '0;
      r = 1;
      for (int i = 0; i < e; i++) r = (r * a) % n;
      return W'(r);
   endfunction

   // Core model: start low holds it idle; busy rises one cycle after start, falls after a
   // random latency with the result, which is then held while start stays high.
   int           cm_state = 0;
   int           cm_cnt = 0;
   logic [W-1:0] cm_res = '0;

   always @(posedge clk) begin
      if (!core_start) begin
         core_busy <= 1'b0;
         cm_state  <= 0;
      end else begin
         case (cm_state)
            0: begin
               core_busy <= 1'b1;
               cm_cnt    <= $urandom_range(lat_max, lat_min);
               cm_res    <= ref_modexp(int'(core_a), int'(core_b), int'(core_c));
               cm_state  <= 1;
            end
            1: begin
               if (!core_stuck) begin
                  if (cm_cnt == 0) begin
                     core_busy <= 1'b0;
                     core_y    <= cm_res;
                     cm_state  <= 2;
                  end else begin
                     cm_cnt <= cm_cnt - 1;
                  end
               end
            end
            default: ;
         endcase
      end
   end

   logic start_prev = 1'b0;
   always @(posedge clk) begin
      start_prev <= core_start;
      if (core_start && !start_prev) start_cnt <= start_cnt + 1;
   end

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      num_checks++;
      if (got !== exp) begin
         num_errors++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
      end
   endtask

   task automatic queue_byte(input int d, input bit last);
      bit err;
      err = (cur_n < 2) || (d >= cur_n);
      stim_data.push_back(W'(d));
      stim_last.push_back(last);
      exp_data.push_back(err ? '0 : ref_modexp(d, cur_e, cur_n));
      exp_err.push_back(err);
      exp_last.push_back(last);
   endtask

   task automatic wait_key_ready();
      int guard = 0;
      @(negedge clk);
      while (!key_ready && guard < 100) begin
         @(negedge clk);
         guard++;
      end
      if (!key_ready) check_eq("key_ready_wait", key_ready, 1);
   endtask

   task automatic load_key(input int e, input int n);
      wait_key_ready();
      key_e    = W'(e);
      key_n    = W'(n);
      key_load = 1'b1;
      @(negedge clk);
      key_load = 1'b0;
      cur_e    = e;
      cur_n    = n;
   endtask

   // Pushes every queued byte with in_valid held high and checks outputs in order, with
   // out_ready randomly withheld bp_pct percent of the time.
   task automatic run_stream(input int bp_pct);
      int nbytes;
      nbytes = stim_data.size();
      @(negedge clk);
      fork
         begin
            int  idx = 0;
            int  guard = 0;
            bit  pend;
            in_valid = 1'b1;
            in_data  = stim_data[0];
            in_last  = stim_last[0];
            pend     = in_ready;
            while (idx < nbytes && guard < BudgetPerByte * nbytes) begin
               @(negedge clk);
               guard++;
               if (pend) begin
                  check_eq("in_ready_after_accept", in_ready, 0);
                  idx++;
                  if (idx < nbytes) begin
                     in_data = stim_data[idx];
                     in_last = stim_last[idx];
                  end else begin
                     in_valid = 1'b0;
                  end
               end
               pend = in_valid && in_ready;
            end
            if (idx != nbytes) check_eq("producer_budget", idx, nbytes);
            in_valid = 1'b0;
         end
         begin
            int got = 0;
            int guard = 0;
            bit stalled = 1'b0;
            while (got < nbytes && guard < BudgetPerByte * nbytes) begin
               @(negedge clk);
               guard++;
               if (stalled) check_eq("valid_held", out_valid, 1);
               out_ready = ($urandom_range(99, 0) >= bp_pct);
               if (out_valid) begin
                  if (exp_data.size() == 0) begin
                     check_eq("unexpected_out", 1, 0);
                  end else begin
                     check_eq("out_data", out_data, exp_data[0]);
                     check_eq("out_err", out_err, exp_err[0]);
                     check_eq("out_last", out_last, exp_last[0]);
                     if (out_ready) begin
                        void'(exp_data.pop_front());
                        void'(exp_err.pop_front());
                        void'(exp_last.pop_front());
                        got++;
                     end
                  end
               end
               stalled = out_valid && !out_ready;
            end
            if (got != nbytes) check_eq("consumer_budget", got, nbytes);
            @(negedge clk);
            out_ready = 1'b0;
         end
      join
      stim_data.delete();
      stim_last.delete();
   endtask

   initial begin
      #500000;
      $display("FAIL global_timeout: got %0d checks expected completion", num_checks);
      $fatal(1, "bench timeout");
   end

   initial begin
      int s0;
      int guard;
      int cycles;

      // Reset state
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      check_eq("rst_key_ready", key_ready, 1);
      check_eq("rst_in_ready", in_ready, 0);
      check_eq("rst_out_valid", out_valid, 0);
      check_eq("rst_out_data", out_data, 0);
      check_eq("rst_out_flags", {out_last, out_err}, 0);
      check_eq("rst_core_start", core_start, 0);
      check_eq("rst_core_abc", {core_a, core_b, core_c}, 0);

      // Single byte: 4^3 mod 33 = 31, then start held low for the release window
      load_key(3, 33);
      check_eq("in_ready_after_key", in_ready, 1);
      queue_byte(4, 1'b1);
      check_eq("ref_4_3_33", exp_data[0], 31);
      run_stream(0);
      @(negedge clk);
      check_eq("release_low_0", core_start, 0);
      @(negedge clk);
      check_eq("release_low_1", core_start, 0);

      // Back-to-back bytes under one key
      load_key(7, 55);
      queue_byte(2, 1'b0);
      queue_byte(3, 1'b0);
      queue_byte(0, 1'b1);
      run_stream(0);

      // Out-of-range byte and degenerate modulus never start the core
      load_key(3, 33);
      s0 = start_cnt;
      queue_byte(40, 1'b1);
      run_stream(0);
      load_key(9, 1);
      queue_byte(0, 1'b0);
      queue_byte(200, 1'b1);
      run_stream(20);
      check_eq("err_no_start", start_cnt - s0, 0);

      // Backpressure with a key_load attempt while busy
      load_key(5, 77);
      queue_byte(6, 1'b1);
      guard = 0;
      while (!in_ready && guard < 100) begin
         @(negedge clk);
         guard++;
      end
      in_valid = 1'b1;
      in_data  = stim_data[0];
      in_last  = stim_last[0];
      @(negedge clk);
      in_valid = 1'b0;
      guard = 0;
      while (!out_valid && guard < 200) begin
         @(negedge clk);
         guard++;
      end
      for (int i = 0; i < 10; i++) begin
         check_eq("bp_valid", out_valid, 1);
         check_eq("bp_data", out_data, exp_data[0]);
         check_eq("bp_last", out_last, exp_last[0]);
         check_eq("bp_in_ready", in_ready, 0);
         check_eq("bp_core_start", core_start, 1);
         check_eq("bp_key_ready", key_ready, 0);
         key_load = (i == 3);
         key_e    = W'(1);
         key_n    = W'(200);
         @(negedge clk);
      end
      key_load  = 1'b0;
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      check_eq("bp_accepted", out_valid, 0);
      stim_data.delete();
      stim_last.delete();
      void'(exp_data.pop_front());
      void'(exp_err.pop_front());
      void'(exp_last.pop_front());
      queue_byte(10, 1'b0);
      run_stream(0);

      // Reset while the core is running
      lat_min = 30;
      lat_max = 30;
      load_key(11, 101);
      in_valid = 1'b1;
      in_data  = W'(7);
      @(negedge clk);
      in_valid = 1'b0;
      guard = 0;
      while (!core_busy && guard < 50) begin
         @(negedge clk);
         guard++;
      end
      check_eq("busy_seen", core_busy, 1);
      @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      check_eq("mid_rst_core_start", core_start, 0);
      check_eq("mid_rst_out_valid", out_valid, 0);
      check_eq("mid_rst_key_ready", key_ready, 1);
      check_eq("mid_rst_in_ready", in_ready, 0);
      repeat (3) @(negedge clk);
      check_eq("mid_rst_in_ready_hold", in_ready, 0);
      lat_min = 1;
      lat_max = 6;

      // Exponent zero passes the core's 1 through
      load_key(0, 77);
      queue_byte(5, 1'b1);
      run_stream(0);

      // Random keys and bytes with random backpressure
      for (int r = 0; r < 6; r++) begin
         int e;
         int n;
         e = $urandom_range(255, 0);
         n = (r == 2) ? $urandom_range(1, 0) : $urandom_range(255, 2);
         load_key(e, n);
         for (int i = 0; i < 8; i++) begin
            int d;
            if ($urandom_range(3, 0) == 0 || n < 2) d = $urandom_range(255, 0);
            else d = $urandom_range(n - 1, 0);
            queue_byte(d, i == 7);
         end
         run_stream(30);
      end

`ifdef RSA_TIMEOUT_EN
      // Stuck core: watchdog forces an error after 16 cycles in LAUNCH/RUN
      core_stuck = 1'b1;
      load_key(3, 33);
      guard = 0;
      while (!in_ready && guard < 100) begin
         @(negedge clk);
         guard++;
      end
      in_valid = 1'b1;
      in_data  = W'(4);
      in_last  = 1'b1;
      cycles   = 0;
      while (!out_valid && cycles < 100) begin
         @(negedge clk);
         in_valid = 1'b0;
         cycles++;
      end
      check_eq("wdog_cycles", cycles, 18);
      check_eq("wdog_err", out_err, 1);
      check_eq("wdog_data", out_data, 0);
      check_eq("wdog_last", out_last, 1);
      check_eq("wdog_start_low", core_start, 0);
      out_ready = 1'b1;
      @(negedge clk);
      out_ready  = 1'b0;
      core_stuck = 1'b0;
      queue_byte(4, 1'b0);
      run_stream(0);
`endif

      check_eq("scoreboard_empty", exp_data.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", num_checks, num_errors);
      $finish;
   end

endmodule
